// File: rtl/image_stream_src.sv
// image_stream_src: fetches an RGB888 frame from word-addressed memory, applies a runtime
// per-pixel operation and streams PPC pixels per beat with VSYNC/HSYNC framing.
module image_stream_src #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int PPC            = 2,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int BOTTOM_UP      = 1,
  parameter int ADDR_W         = 20
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                start,
  input  logic [2:0]          mode,
  input  logic [7:0]          value,
  input  logic [7:0]          threshold,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [24*PPC-1:0]   mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [24*PPC-1:0]   out_data,
  output logic                out_sol,
  output logic                out_eol,
  output logic                VSYNC,
  output logic                HSYNC,
  output logic                ctrl_done,
  output logic                busy
);

  localparam int          DW       = 24 * PPC;
  localparam int          WPL      = WIDTH / PPC;
  localparam logic [15:0] VS_END   = 16'(START_UP_DELAY);
  localparam logic [15:0] HS_END   = 16'(HSYNC_DELAY);
  localparam logic [15:0] LAST_COL = 16'(WPL - 1);
  localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_VSYNC, ST_HSYNC, ST_DATA, ST_DRAIN
  } state_t;

  typedef struct packed {
    logic          sol;
    logic          eol;
    logic [DW-1:0] data;
  } beat_t;

  state_t        state;
  logic [15:0]   vsync_cnt, hsync_cnt, row, colw;
  logic [2:0]    mode_q;
  logic [7:0]    value_q, thr_q;
  logic          rd_pend, pend_sol, pend_eol;
  beat_t         fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_cnt;
  logic          pop, can_issue;
  logic [2:0]    level;
  logic [15:0]   row_eff;
  logic [DW-1:0] proc_data;

  function automatic logic [23:0] proc_pixel(input logic [23:0] px, input logic [2:0] op,
                                             input logic [7:0] val, input logic [7:0] thr);
    logic [23:0] res;
    logic [9:0]  sum;
    logic [9:0]  lim;
    logic [8:0]  t;
    res = px;
    t   = '0;
    sum = 10'(px[23:16]) + 10'(px[15:8]) + 10'(px[7:0]);
    lim = 10'(thr) * 10'd3;
    for (int c = 0; c < 3; c++) begin
      case (op)
        3'd1: begin
          t = {1'b0, px[8*c +: 8]} + {1'b0, val};
          res[8*c +: 8] = t[8] ? 8'hFF : t[7:0];
        end
        3'd2: begin
          // A borrow out of the 9-bit difference means the result went negative.
          t = {1'b0, px[8*c +: 8]} - {1'b0, val};
          res[8*c +: 8] = t[8] ? 8'h00 : t[7:0];
        end
        3'd3:    res[8*c +: 8] = ~px[8*c +: 8];
        3'd4:    res[8*c +: 8] = (sum >= lim) ? 8'hFF : 8'h00;
        default: ;
      endcase
    end
    return res;
  endfunction

  always_comb begin
    // NOTE: blocking assignments with a default first, so every path assigns and no latch forms.
    proc_data = '0;
    for (int k = 0; k < PPC; k++)
      proc_data[24*k +: 24] = proc_pixel(mem_rdata[24*k +: 24], mode_q, value_q, thr_q);
  end

  // Issue only while the FIFO can absorb everything already requested.
  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign level     = 3'(fifo_cnt) + 3'(rd_pend) - 3'(pop);
  assign can_issue = (level < 3'd2);
  assign mem_rd    = (state == ST_DATA) && can_issue;
  assign row_eff   = (BOTTOM_UP != 0) ? (LAST_ROW - row) : row;
  assign mem_addr  = mem_rd ? (ADDR_W'(row_eff) * ADDR_W'(WPL) + ADDR_W'(colw)) : '0;

  assign out_data  = fifo_mem[rd_ptr].data;
  assign out_sol   = fifo_mem[rd_ptr].sol;
  assign out_eol   = fifo_mem[rd_ptr].eol;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!HRESETn) begin
      state     <= ST_IDLE;
      vsync_cnt <= '0;
      hsync_cnt <= '0;
      row       <= '0;
      colw      <= '0;
      mode_q    <= '0;
      value_q   <= '0;
      thr_q     <= '0;
      VSYNC     <= 1'b0;
      HSYNC     <= 1'b0;
      busy      <= 1'b0;
      ctrl_done <= 1'b0;
    end else begin
      ctrl_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            value_q <= value;
            thr_q   <= threshold;
            state   <= ST_VSYNC;
            VSYNC   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_VSYNC: begin
          if (vsync_cnt == VS_END) begin
            vsync_cnt <= '0;
            state     <= ST_HSYNC;
            VSYNC     <= 1'b0;
          end else begin
            vsync_cnt <= vsync_cnt + 16'd1;
          end
        end
        ST_HSYNC: begin
          if (hsync_cnt == HS_END) begin
            hsync_cnt <= '0;
            state     <= ST_DATA;
            HSYNC     <= 1'b1;
          end else begin
            hsync_cnt <= hsync_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (mem_rd) begin
            if (colw == LAST_COL) begin
              colw  <= '0;
              HSYNC <= 1'b0;
              if (row == LAST_ROW) begin
                row   <= '0;
                state <= ST_DRAIN;
              end else begin
                row   <= row + 16'd1;
                state <= ST_HSYNC;
              end
            end else begin
              colw <= colw + 16'd1;
            end
          end
        end
        ST_DRAIN: begin
          // Final beat leaves when it is the only one held and nothing is still in flight.
          if (pop && (fifo_cnt == 2'd1) && !rd_pend) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            ctrl_done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          VSYNC <= 1'b0;
          HSYNC <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_pend  <= 1'b0;
      pend_sol <= 1'b0;
      pend_eol <= 1'b0;
    end else begin
      rd_pend  <= mem_rd;
      pend_sol <= mem_rd && (colw == 16'd0);
      pend_eol <= mem_rd && (colw == LAST_COL);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      // NOTE: the two storage entries are reset because they drive out_data directly.
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= '0;
    end else begin
      if (rd_pend) begin
        fifo_mem[wr_ptr] <= {pend_sol, pend_eol, proc_data};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(rd_pend) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_image_stream_src.sv
// Self-checking bench for image_stream_src: random frames scored against a plain-arithmetic
// model of the expected beat sequence, plus directed framing, timing and control scenarios.
module tb_image_stream_src;

  localparam int W      = 16;
  localparam int H      = 4;
  localparam int P      = 4;
  localparam int SUD    = 5;
  localparam int HSD    = 3;
  localparam int BU     = 1;
  localparam int AW     = 6;
  localparam int DW     = 24 * P;
  localparam int WPL    = W / P;
  localparam int NBEATS = W * H / P;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    mode = '0;
  logic [7:0]    value = '0;
  logic [7:0]    threshold = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_sol, out_eol, VSYNC, HSYNC, ctrl_done, busy;

  image_stream_src #(
    .WIDTH(W), .HEIGHT(H), .PPC(P), .START_UP_DELAY(SUD),
    .HSYNC_DELAY(HSD), .BOTTOM_UP(BU), .ADDR_W(AW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode), .value(value),
    .threshold(threshold), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sol(out_sol),
    .out_eol(out_eol), .VSYNC(VSYNC), .HSYNC(HSYNC), .ctrl_done(ctrl_done), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc;
  logic bp_en = 1'b0;

  logic [DW-1:0] mem_arr [64];

  always @(posedge HCLK) cyc <= cyc + 1;

  // Frame memory: data is only present in the cycle right after the strobe.
  always @(posedge HCLK) begin
    if (mem_rd) mem_rdata <= mem_arr[mem_addr];
    else        mem_rdata <= '0;
  end

  always @(posedge HCLK) begin
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 2) != 0);
    else       out_ready = 1'b1;
  end

  logic [DW-1:0] beat_data_q[$];
  logic          beat_sol_q[$];
  logic          beat_eol_q[$];
  int            addr_q[$];
  int            hs_gap_q[$];
  int vs_cycles, done_pulses, done_cyc, last_pop_cyc, first_rd_cyc, first_vld_cyc, first_vs_cyc;
  int occ_viol, stall_viol, rd_total, pop_total, gap;
  logic          prev_stall, prev_hs, mon_pop;
  logic [DW-1:0] prev_data;

  always @(negedge HCLK) begin
    if (HRESETn) begin
      mon_pop = out_valid && out_ready;
      if (mem_rd) begin
        if (rd_total - pop_total - (mon_pop ? 1 : 0) >= 2) occ_viol++;
        addr_q.push_back(int'(mem_addr));
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        rd_total++;
      end
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (mon_pop) begin
        beat_data_q.push_back(out_data);
        beat_sol_q.push_back(out_sol);
        beat_eol_q.push_back(out_eol);
        pop_total++;
        last_pop_cyc = cyc;
      end
      if (VSYNC) begin
        vs_cycles++;
        if (first_vs_cyc < 0) first_vs_cyc = cyc;
        gap = 0;
      end else if (busy && !HSYNC) begin
        gap++;
      end
      if (HSYNC && !prev_hs) begin
        hs_gap_q.push_back(gap);
        gap = 0;
      end
      prev_hs = HSYNC;
      if (ctrl_done) begin
        done_pulses++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [23:0] model_px(input logic [23:0] p, input logic [2:0] m,
                                           input int v, input int t);
    int c[3];
    int s, x;
    logic [23:0] o;
    c[2] = int'(p[23:16]);
    c[1] = int'(p[15:8]);
    c[0] = int'(p[7:0]);
    s = c[0] + c[1] + c[2];
    o = '0;
    for (int i = 0; i < 3; i++) begin
      x = c[i];
      case (m)
        3'd1:    x = (x + v > 255) ? 255 : x + v;
        3'd2:    x = (x - v < 0) ? 0 : x - v;
        3'd3:    x = 255 - x;
        3'd4:    x = (s >= 3 * t) ? 255 : 0;
        default: ;
      endcase
      o[8*i +: 8] = 8'(x);
    end
    return o;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < P; k++)
        mem_arr[i][24*k +: 24] = 24'($urandom);
  endtask

  task automatic clear_monitor();
    beat_data_q.delete(); beat_sol_q.delete(); beat_eol_q.delete();
    addr_q.delete(); hs_gap_q.delete();
    vs_cycles = 0; done_pulses = 0; done_cyc = -1; last_pop_cyc = -1;
    first_rd_cyc = -1; first_vld_cyc = -1; first_vs_cyc = -1;
    occ_viol = 0; stall_viol = 0; rd_total = 0; pop_total = 0; gap = 0;
    prev_stall = 1'b0; prev_hs = 1'b0; prev_data = '0;
  endtask

  task automatic start_frame(input logic [2:0] m, input logic [7:0] v, input logic [7:0] t);
    @(posedge HCLK); #2;
    clear_monitor();
    mode = m; value = v; threshold = t; start = 1'b1;
    start_cyc = cyc;
    @(posedge HCLK); #2;
    start = 1'b0;
    mode = 3'($urandom); value = 8'($urandom); threshold = 8'($urandom);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_pulses == 0 && n < 3000) begin
      @(negedge HCLK);
      n++;
    end
    n_checks++;
    if (done_pulses == 0) $display("FAIL %s done_timeout: no ctrl_done after %0d cycles", name, n);
    else n_pass++;
    repeat (3) @(negedge HCLK);
  endtask

  task automatic verify_frame(input string name, input logic [2:0] m, input int v, input int t);
    logic [DW-1:0] ed;
    logic es, ee;
    int ea, n;
    n = 0;
    n_checks++;
    if (beat_data_q.size() != NBEATS)
      $display("FAIL %s beat_count: got %0d expected %0d", name, beat_data_q.size(), NBEATS);
    else n_pass++;
    n_checks++;
    if (addr_q.size() != NBEATS)
      $display("FAIL %s read_count: got %0d expected %0d", name, addr_q.size(), NBEATS);
    else n_pass++;
    for (int r = 0; r < H; r++) begin
      for (int cw = 0; cw < WPL; cw++) begin
        ea = ((BU != 0) ? (H - 1 - r) : r) * WPL + cw;
        for (int k = 0; k < P; k++) ed[24*k +: 24] = model_px(mem_arr[ea][24*k +: 24], m, v, t);
        es = (cw == 0);
        ee = (cw == WPL - 1);
        if (n < beat_data_q.size()) begin
          n_checks++;
          if ({beat_sol_q[n], beat_eol_q[n], beat_data_q[n]} !== {es, ee, ed})
            $display("FAIL %s beat%0d: got sol=%b eol=%b data=%h expected sol=%b eol=%b data=%h",
                     name, n, beat_sol_q[n], beat_eol_q[n], beat_data_q[n], es, ee, ed);
          else n_pass++;
        end
        if (n < addr_q.size()) begin
          n_checks++;
          if (addr_q[n] != ea)
            $display("FAIL %s addr%0d: got %0d expected %0d", name, n, addr_q[n], ea);
          else n_pass++;
        end
        n++;
      end
    end
    n_checks++;
    if (done_pulses != 1) $display("FAIL %s done_pulses: got %0d expected 1", name, done_pulses);
    else n_pass++;
    n_checks++;
    if (done_cyc != last_pop_cyc + 1)
      $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, last_pop_cyc + 1);
    else n_pass++;
    n_checks++;
    if (occ_viol != 0) $display("FAIL %s occupancy: got %0d overfull reads expected 0", name, occ_viol);
    else n_pass++;
    n_checks++;
    if (stall_viol != 0) $display("FAIL %s stall_stability: got %0d changes expected 0", name, stall_viol);
    else n_pass++;
  endtask

  task automatic run_frame(input string name, input logic [2:0] m, input logic [7:0] v,
                           input logic [7:0] t);
    start_frame(m, v, t);
    wait_done(name);
    verify_frame(name, m, int'(v), int'(t));
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    n_checks++;
    if ({mem_rd, mem_addr, out_valid, out_data, out_sol, out_eol, VSYNC, HSYNC, ctrl_done} !== '0)
      $display("FAIL reset_outputs: got rd=%b addr=%h vld=%b data=%h vs=%b hs=%b done=%b expected all 0",
               mem_rd, mem_addr, out_valid, out_data, VSYNC, HSYNC, ctrl_done);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else n_pass++;
    @(posedge HCLK); #2;
    HRESETn = 1'b1;
    repeat (5) @(negedge HCLK);
    n_checks++;
    if ({busy, VSYNC, mem_rd} !== 3'b000) $display("FAIL idle_no_start: got busy/vs/rd=%b expected 000", {busy, VSYNC, mem_rd});
    else n_pass++;
  endtask

  task automatic test_pass_through();
    fill_mem();
    run_frame("pass", 3'd0, 8'd0, 8'd0);
    n_checks++;
    if (addr_q.size() == 0 || addr_q[0] != (H - 1) * WPL)
      $display("FAIL pass_first_addr: got %0d expected %0d", addr_q.size() ? addr_q[0] : -1, (H - 1) * WPL);
    else n_pass++;
  endtask

  task automatic test_timing();
    fill_mem();
    run_frame("timing", 3'($urandom_range(5, 7)), 8'($urandom), 8'($urandom));
    n_checks++;
    if (vs_cycles != SUD + 1) $display("FAIL vsync_len: got %0d expected %0d", vs_cycles, SUD + 1);
    else n_pass++;
    n_checks++;
    if (first_vs_cyc != start_cyc + 1)
      $display("FAIL vsync_start: got cycle %0d expected %0d", first_vs_cyc, start_cyc + 1);
    else n_pass++;
    n_checks++;
    if (hs_gap_q.size() != H) $display("FAIL line_count: got %0d expected %0d", hs_gap_q.size(), H);
    else n_pass++;
    foreach (hs_gap_q[i]) begin
      n_checks++;
      if (hs_gap_q[i] != HSD + 1) $display("FAIL hsync_gap%0d: got %0d expected %0d", i, hs_gap_q[i], HSD + 1);
      else n_pass++;
    end
    n_checks++;
    if (first_vld_cyc - first_rd_cyc != 2)
      $display("FAIL first_latency: got %0d expected 2", first_vld_cyc - first_rd_cyc);
    else n_pass++;
  endtask

  task automatic test_ops();
    logic [23:0] got;
    logic [2:0]  m;
    logic [7:0]  v;
    logic [23:0] want;
    int          pix;
    for (int s = 0; s < 5; s++) begin
      fill_mem();
      mem_arr[(H - 1) * WPL] = {24'h646463, 24'h646464, 24'h0080FF, 24'hC80A9B};
      case (s)
        0:       begin m = 3'd1; v = 8'd100; pix = 0; want = 24'hFF6EFF; end
        1:       begin m = 3'd2; v = 8'd100; pix = 0; want = 24'h640037; end
        2:       begin m = 3'd3; v = 8'd0;   pix = 1; want = 24'hFF7F00; end
        3:       begin m = 3'd4; v = 8'd0;   pix = 2; want = 24'hFFFFFF; end
        default: begin m = 3'd4; v = 8'd0;   pix = 3; want = 24'h000000; end
      endcase
      run_frame("ops", m, v, 8'd100);
      got = (beat_data_q.size() > 0) ? beat_data_q[0][24*pix +: 24] : 24'hxxxxxx;
      n_checks++;
      if (got !== want) $display("FAIL op_mode%0d_px%0d: got %h expected %h", m, pix, got, want);
      else n_pass++;
    end
    for (int s = 0; s < 4; s++) begin
      fill_mem();
      run_frame("ops_rand", 3'($urandom_range(1, 4)), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_back_pressure();
    bp_en = 1'b1;
    for (int s = 0; s < 3; s++) begin
      fill_mem();
      run_frame("backpressure", 3'($urandom), 8'($urandom), 8'($urandom));
    end
    bp_en = 1'b0;
  endtask

  task automatic test_start_ignored();
    int n;
    fill_mem();
    start_frame(3'd3, 8'd0, 8'd0);
    n = 0;
    while (!HSYNC && n < 200) begin @(negedge HCLK); n++; end
    n_checks++;
    if (!HSYNC) $display("FAIL start_ign_reach_data: got HSYNC=%b expected 1", HSYNC);
    else n_pass++;
    @(posedge HCLK); #2;
    start = 1'b1; mode = 3'd1;
    @(posedge HCLK); #2;
    start = 1'b0;
    wait_done("start_ignored");
    verify_frame("start_ignored", 3'd3, 0, 0);
    repeat (15) @(negedge HCLK);
    n_checks++;
    if (busy !== 1'b0 || vs_cycles != SUD + 1)
      $display("FAIL start_not_queued: got busy=%b vsync_cycles=%0d expected 0 and %0d", busy, vs_cycles, SUD + 1);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int n;
    fill_mem();
    start_frame(3'd2, 8'd40, 8'd0);
    n = 0;
    while (!HSYNC && n < 200) begin @(negedge HCLK); n++; end
    repeat (2) @(negedge HCLK);
    @(posedge HCLK); #2;
    HRESETn = 1'b0;
    @(negedge HCLK);
    n_checks++;
    if ({mem_rd, mem_addr, out_valid, out_data, out_sol, out_eol, VSYNC, HSYNC, ctrl_done, busy} !== '0)
      $display("FAIL midreset_outputs: got rd=%b vld=%b data=%h hs=%b busy=%b expected all 0",
               mem_rd, out_valid, out_data, HSYNC, busy);
    else n_pass++;
    repeat (2) @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    repeat (10) @(negedge HCLK);
    n_checks++;
    if (busy !== 1'b0 || done_pulses != 0 || out_valid !== 1'b0)
      $display("FAIL midreset_abort: got busy=%b done=%0d vld=%b expected 0 0 0", busy, done_pulses, out_valid);
    else n_pass++;
    fill_mem();
    run_frame("after_reset", 3'd1, 8'd77, 8'd0);
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_timing();
    test_ops();
    test_back_pressure();
    test_start_ignored();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
